// File: rtl/ins_defs_pkg.sv
// Shared definitions for the instruction sequencer: default widths,
// opcode values, FSM state encoding and the default per-opcode length table.
package ins_defs_pkg;

   localparam int IR_W_DEF   = 8;
   localparam int OP_W_DEF   = 4;
   localparam int STEP_W_DEF = 3;

   localparam logic [3:0] OP_ILL0 = 4'b0000;
   localparam logic [3:0] OP_PUSH = 4'b0001;
   localparam logic [3:0] OP_POP  = 4'b0010;
   localparam logic [3:0] OP_ILL1 = 4'b0011;
   localparam logic [3:0] OP_MOVA = 4'b0100;
   localparam logic [3:0] OP_MOVB = 4'b0101;
   localparam logic [3:0] OP_MOVC = 4'b0110;
   localparam logic [3:0] OP_MOVD = 4'b0111;
   localparam logic [3:0] OP_ADD  = 4'b1000;
   localparam logic [3:0] OP_SUB  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1010;
   localparam logic [3:0] OP_JG   = 4'b1011;
   localparam logic [3:0] OP_IN   = 4'b1100;
   localparam logic [3:0] OP_OUT  = 4'b1101;
   localparam logic [3:0] OP_MOVI = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Lane i (bits [i*3 +: 3]) is the length of opcode i; listed from lane 15 down to lane 0.
   localparam logic [47:0] OP_LEN_DEF = {
      3'd1, 3'd2, 3'd1, 3'd1,   // halt, movi, out, in
      3'd2, 3'd1, 3'd2, 3'd2,   // jg, jmp, sub, add
      3'd1, 3'd1, 3'd1, 3'd1,   // movd, movc, movb, mova
      3'd1, 3'd2, 3'd2, 3'd1    // ill1, pop, push, ill0
   };

endpackage

// File: rtl/ins_onehot.sv
// Combinational opcode decoder: one-hot opcode vector plus class flags
// used by the sequencer for accept gating, halting, jg shortening and
// illegal-opcode flagging.
module ins_onehot
   import ins_defs_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic [OP_W-1:0]      op,
   output logic [2**OP_W-1:0]   onehot,
   output logic                 is_stack,
   output logic                 is_halt,
   output logic                 is_jg,
   output logic                 is_illegal
);

   // Decode the opcode into its one-hot bit and class flags.
   always_comb begin
      onehot     = {(2**OP_W){1'b0}};
      onehot[op] = 1'b1;
      is_stack   = (op == OP_W'(OP_PUSH)) | (op == OP_W'(OP_POP));
      is_halt    = (op == OP_W'(OP_HALT));
      is_jg      = (op == OP_W'(OP_JG));
      is_illegal = (op == OP_W'(OP_ILL0)) | (op == OP_W'(OP_ILL1));
   end

endmodule

// File: rtl/ins_sequencer.sv
// Multi-cycle instruction sequencer: accepts an instruction over valid/ready,
// holds its one-hot opcode for a per-opcode number of micro-steps and drives
// the step counter, with jg shortening, halt/resume and abort flush.
module ins_sequencer
   import ins_defs_pkg::*;
#(
   parameter int IR_W   = IR_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int STEP_W = STEP_W_DEF,
   parameter logic [(2**OP_W)*STEP_W-1:0] OP_LEN = OP_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 ir_valid,
   input  logic [IR_W-1:0]      ir,
   output logic                 ir_ready,
   input  logic                 gt_flag,
   input  logic                 resume,
   input  logic                 abort,
   output logic [2**OP_W-1:0]   op_onehot,
   output logic [STEP_W-1:0]    step,
   output logic                 step_last,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal
);

   localparam int NOH = 2**OP_W;

   state_t               state_r,     state_n;
   logic [NOH-1:0]       op_onehot_r, op_onehot_n;
   logic [STEP_W-1:0]    step_r,      step_n;
   logic                 step_last_r, step_last_n;
   logic                 busy_r,      busy_n;
   logic                 halted_r,    halted_n;
   logic                 illegal_r,   illegal_n;
   logic [STEP_W-1:0]    len_r,       len_n;
   logic                 halt_op_r,   halt_op_n;

   logic [OP_W-1:0]      op_in_s;
   logic [NOH-1:0]       dec_onehot_s;
   logic                 dec_stack_s;
   logic                 dec_halt_s;
   logic                 dec_jg_s;
   logic                 dec_illegal_s;
   logic [STEP_W-1:0]    len_raw_s;
   logic [STEP_W-1:0]    len_in_s;
   logic                 slot_open_s;
   logic                 ir_ready_s;
   logic                 accept_s;
   logic                 unused_s;

   assign op_in_s  = ir[IR_W-1 -: OP_W];
   assign unused_s = ^ir[IR_W-OP_W-1:0];

   ins_onehot #(.OP_W(OP_W)) u_dec (
      .op         (op_in_s),
      .onehot     (dec_onehot_s),
      .is_stack   (dec_stack_s),
      .is_halt    (dec_halt_s),
      .is_jg      (dec_jg_s),
      .is_illegal (dec_illegal_s)
   );

   // Look up the offered opcode's length; a zero lane behaves as length 1.
   always_comb begin
      len_raw_s = OP_LEN[int'(op_in_s)*STEP_W +: STEP_W];
      if (len_raw_s == {STEP_W{1'b0}}) begin
         len_in_s = STEP_W'(1);
      end else begin
         len_in_s = len_raw_s;
      end
   end

   // Ready when idle or finishing a non-halt op; stack ops pass while disabled.
   always_comb begin
      if (state_r == ST_IDLE) begin
         slot_open_s = 1'b1;
      end else if (state_r == ST_EXEC) begin
         slot_open_s = step_last_r & ~halt_op_r;
      end else begin
         slot_open_s = 1'b0;
      end
      ir_ready_s = slot_open_s & ~abort & (en | dec_stack_s);
      accept_s   = ir_valid & ir_ready_s;
   end

   assign ir_ready = ir_ready_s;

   // Next-state and next-output logic: abort first, then accept, then stepping.
   always_comb begin
      state_n     = state_r;
      op_onehot_n = op_onehot_r;
      step_n      = step_r;
      step_last_n = step_last_r;
      busy_n      = busy_r;
      halted_n    = halted_r;
      illegal_n   = illegal_r;
      len_n       = len_r;
      halt_op_n   = halt_op_r;
      if (abort) begin
         state_n     = ST_IDLE;
         op_onehot_n = {NOH{1'b0}};
         step_n      = {STEP_W{1'b0}};
         step_last_n = 1'b0;
         busy_n      = 1'b0;
         halted_n    = 1'b0;
         illegal_n   = 1'b0;
         len_n       = STEP_W'(1);
         halt_op_n   = 1'b0;
      end else if (accept_s) begin
         state_n     = ST_EXEC;
         op_onehot_n = dec_onehot_s;
         step_n      = {STEP_W{1'b0}};
         step_last_n = (len_in_s == STEP_W'(1)) | (dec_jg_s & ~gt_flag);
         busy_n      = 1'b1;
         halted_n    = 1'b0;
         illegal_n   = dec_illegal_s;
         len_n       = len_in_s;
         halt_op_n   = dec_halt_s;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_n = ST_IDLE;
            end
            ST_EXEC: begin
               if (step_last_r) begin
                  if (halt_op_r) begin
                     state_n  = ST_HALT;
                     halted_n = 1'b1;
                  end else begin
                     state_n  = ST_IDLE;
                     halted_n = 1'b0;
                  end
                  op_onehot_n = {NOH{1'b0}};
                  step_n      = {STEP_W{1'b0}};
                  step_last_n = 1'b0;
                  busy_n      = 1'b0;
                  illegal_n   = 1'b0;
                  len_n       = STEP_W'(1);
                  halt_op_n   = 1'b0;
               end else begin
                  step_n      = step_r + STEP_W'(1);
                  step_last_n = ((step_r + STEP_W'(1)) == (len_r - STEP_W'(1)));
                  illegal_n   = 1'b0;
               end
            end
            ST_HALT: begin
               if (resume) begin
                  state_n  = ST_IDLE;
                  halted_n = 1'b0;
               end else begin
                  state_n  = ST_HALT;
                  halted_n = 1'b1;
               end
            end
            default: begin
               state_n     = ST_IDLE;
               op_onehot_n = {NOH{1'b0}};
               step_n      = {STEP_W{1'b0}};
               step_last_n = 1'b0;
               busy_n      = 1'b0;
               halted_n    = 1'b0;
               illegal_n   = 1'b0;
               len_n       = STEP_W'(1);
               halt_op_n   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset to the idle values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         op_onehot_r <= {NOH{1'b0}};
         step_r      <= {STEP_W{1'b0}};
         step_last_r <= 1'b0;
         busy_r      <= 1'b0;
         halted_r    <= 1'b0;
         illegal_r   <= 1'b0;
         len_r       <= STEP_W'(1);
         halt_op_r   <= 1'b0;
      end else begin
         state_r     <= state_n;
         op_onehot_r <= op_onehot_n;
         step_r      <= step_n;
         step_last_r <= step_last_n;
         busy_r      <= busy_n;
         halted_r    <= halted_n;
         illegal_r   <= illegal_n;
         len_r       <= len_n;
         halt_op_r   <= halt_op_n;
      end
   end

   assign op_onehot = op_onehot_r;
   assign step      = step_r;
   assign step_last = step_last_r;
   assign busy      = busy_r;
   assign halted    = halted_r;
   assign illegal   = illegal_r;

endmodule

// File: tb/tb_ins_sequencer.sv
// Bench for ins_sequencer: directed scenarios with constant expectations,
// then randomized traffic against a cycle-level behavioural model.
module tb_ins_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ir_valid = 1'b0;
   logic [7:0]  ir = 8'h00;
   logic        ir_ready;
   logic        gt_flag = 1'b0;
   logic        resume = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] op_onehot;
   logic [2:0]  step;
   logic        step_last;
   logic        busy;
   logic        halted;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   // obs = {op_onehot, step, step_last, busy, halted, illegal}
   logic [22:0] obs;
   assign obs = {op_onehot, step, step_last, busy, halted, illegal};
   localparam logic [22:0] IDLE_OBS = 23'd0;

   ins_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .ir_valid(ir_valid), .ir(ir),
      .ir_ready(ir_ready), .gt_flag(gt_flag), .resume(resume), .abort(abort),
      .op_onehot(op_onehot), .step(step), .step_last(step_last),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic offer(input logic [3:0] op);
      ir_valid = 1'b1;
      ir = {op, 4'($urandom)};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL reset_obs got=%h exp=%h", obs, IDLE_OBS); end
      total++; if (ir_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ir_ready); end
      rst = 1'b0;
   endtask

   task automatic test_add();
      @(negedge clk); en = 1'b1; offer(4'b1000); #1;
      total++; if (ir_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", ir_ready); end
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL add_s0 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== {16'h0100, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL add_s1 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL add_end got=%h exp=%h", obs, IDLE_OBS); end
   endtask

   task automatic test_stack_disabled();
      @(negedge clk); en = 1'b0; offer(4'b0100); #1;
      total++; if (ir_ready !== 1'b0) begin bad++; $display("FAIL dis_mova_ready got=%b exp=0", ir_ready); end
      @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL dis_mova_stall got=%h exp=%h", obs, IDLE_OBS); end
      offer(4'b0001); #1;
      total++; if (ir_ready !== 1'b1) begin bad++; $display("FAIL dis_push_ready got=%b exp=1", ir_ready); end
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0002, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL push_s0 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== {16'h0002, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL push_s1 got=%h", obs); end
      @(negedge clk); en = 1'b1;
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL push_end got=%h exp=%h", obs, IDLE_OBS); end
   endtask

   task automatic test_jg();
      @(negedge clk); gt_flag = 1'b0; offer(4'b1011);
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0800, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL jg0_s0 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL jg0_end got=%h exp=%h", obs, IDLE_OBS); end
      gt_flag = 1'b1; offer(4'b1011);
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0800, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL jg1_s0 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== {16'h0800, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL jg1_s1 got=%h", obs); end
      @(negedge clk); gt_flag = 1'b0;
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL jg1_end got=%h exp=%h", obs, IDLE_OBS); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_oh [6] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h4000, 16'h4000};
      int busy_cnt = 0;
      @(negedge clk); offer(4'b1000);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (c < 6) begin
            total++;
            if (op_onehot !== exp_oh[c] || step !== 3'(c % 2)) begin
               bad++; $display("FAIL b2b_cycle%0d got oh=%h step=%0d exp oh=%h step=%0d", c, op_onehot, step, exp_oh[c], c % 2);
            end
         end
         if (c == 1 || c == 3) begin
            offer(c == 1 ? 4'b1001 : 4'b1110); #1;
            total++; if (ir_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", c, ir_ready); end
         end
         if (c == 5) ir_valid = 1'b0;
      end
      total++; if (busy_cnt !== 6) begin bad++; $display("FAIL b2b_busy_cycles got=%0d exp=6", busy_cnt); end
   endtask

   task automatic test_halt();
      @(negedge clk); offer(4'b1111);
      @(negedge clk); offer(4'b1010); #1;
      total++; if ({obs, ir_ready} !== {16'h8000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL halt_s0 got=%h", {obs, ir_ready}); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         total++;
         if ({obs, ir_ready} !== {16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL halt_hold%0d got=%h", i, {obs, ir_ready});
         end
      end
      resume = 1'b1;
      @(negedge clk); resume = 1'b0; #1;
      total++; if ({obs, ir_ready} !== {IDLE_OBS, 1'b1}) begin bad++; $display("FAIL resume_idle got=%h", {obs, ir_ready}); end
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0400, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL resume_jmp got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL jmp_end got=%h exp=%h", obs, IDLE_OBS); end
   endtask

   task automatic test_abort_reset_illegal();
      @(negedge clk); offer(4'b1110);
      @(negedge clk); offer(4'b1000);
      @(negedge clk); abort = 1'b1; #1;
      total++; if ({obs, ir_ready} !== {16'h4000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL abort_s1 got=%h", {obs, ir_ready}); end
      @(negedge clk); abort = 1'b0; ir_valid = 1'b0;
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL abort_flush got=%h exp=%h", obs, IDLE_OBS); end
      offer(4'b1001);
      @(negedge clk); ir_valid = 1'b0;
      #2 rst = 1'b1; #1;
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL rst_mid got=%h exp=%h", obs, IDLE_OBS); end
      @(negedge clk); rst = 1'b0; offer(4'b0011);
      @(negedge clk); ir_valid = 1'b0;
      total++; if (obs !== {16'h0008, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1}) begin bad++; $display("FAIL illegal_s0 got=%h", obs); end
      @(negedge clk);
      total++; if (obs !== IDLE_OBS) begin bad++; $display("FAIL illegal_end got=%h exp=%h", obs, IDLE_OBS); end
   endtask

   task automatic test_random();
      int lens [16] = '{1, 2, 2, 1, 1, 1, 1, 1, 2, 2, 1, 2, 1, 1, 2, 1};
      bit m_busy = 1'b0, m_halted = 1'b0, m_last, exp_rdy;
      int m_op = 0, m_step = 0, m_len = 1, op_in;
      logic [22:0] exp_obs;
      rst = 1'b1; ir_valid = 1'b0; abort = 1'b0; resume = 1'b0;
      @(negedge clk); rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         m_last = m_busy && (m_step == m_len - 1);
         exp_obs = {m_busy ? (16'd1 << m_op) : 16'd0, m_busy ? 3'(m_step) : 3'd0, m_last, m_busy, m_halted,
                    m_busy && (m_op == 0 || m_op == 3) && m_step == 0};
         total++; if (obs !== exp_obs) begin bad++; $display("FAIL rand_obs cyc=%0d got=%h exp=%h", cyc, obs, exp_obs); end
         ir_valid = ($urandom % 4) != 0;
         ir       = 8'($urandom);
         en       = ($urandom % 4) != 0;
         abort    = ($urandom % 24) == 0;
         resume   = ($urandom % 6) == 0;
         if (!m_busy) gt_flag = 1'($urandom);
         #1;
         op_in   = int'(ir[7:4]);
         exp_rdy = !abort && ((!m_busy && !m_halted) || (m_last && m_op != 15)) && (en || op_in == 1 || op_in == 2);
         total++; if (ir_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, ir_ready, exp_rdy); end
         if (abort) begin
            m_busy = 1'b0; m_halted = 1'b0;
         end else if (ir_valid && exp_rdy) begin
            m_busy = 1'b1; m_halted = 1'b0; m_op = op_in; m_step = 0;
            m_len = (op_in == 11 && !gt_flag) ? 1 : lens[op_in];
         end else if (m_busy) begin
            if (m_last) begin
               m_busy = 1'b0; m_halted = (m_op == 15);
            end else begin
               m_step++;
            end
         end else if (m_halted && resume) begin
            m_halted = 1'b0;
         end
      end
      ir_valid = 1'b0; abort = 1'b0; resume = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_stack_disabled();
      test_jg();
      test_back_to_back();
      test_halt();
      test_abort_reset_illegal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
